// File: rtl/engine_request_arbiter_n_to_1.sv
// Round-robin N-to-1 arbiter that pops engine request FIFOs and funnels the
// granted packets into a first-word-fall-through output buffer.
package engine_request_arbiter_pkg;
   localparam int unsigned PAYLOAD_W = 32;

   typedef struct packed {
      logic                 valid;
      logic [PAYLOAD_W-1:0] payload;
   } memory_request_packet_t;
endpackage

module engine_request_arbiter_n_to_1
   import engine_request_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQUESTORS     = 4,
   parameter int unsigned FIFO_DEPTH         = 16,
   parameter int unsigned ALMOST_FULL_THRESH = 12
) (
   input  logic                                        ap_clk,
   input  logic                                        areset_n,
   input  memory_request_packet_t [NUM_REQUESTORS-1:0] req_in,
   output logic [NUM_REQUESTORS-1:0]                   grant_out,
   output memory_request_packet_t                      req_out,
   input  logic                                        req_out_ready,
   output logic                                        fifo_almost_full,
   output logic                                        fifo_empty,
   output logic                                        arbiter_busy
);

   localparam int unsigned PTR_W  = $clog2(NUM_REQUESTORS);
   localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(ALMOST_FULL_THRESH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_IDLE,
      ST_BUSY,
      ST_PAUSE
   } state_t;

   logic [1:0]                rst_sync_q;
   logic                      rst_n;
   state_t                    state_q;
   logic                      busy_q;
   logic [NUM_REQUESTORS-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [NUM_REQUESTORS-1:0] eligible;
   logic                      any_valid;
   logic                      can_grant;
   logic                      push, pop;
   logic [PAYLOAD_W-1:0]      push_payload;
   logic [CNT_W-1:0]          count_q, count_d, occupancy;
   logic [ADDR_W-1:0]         wr_ptr_q, rd_ptr_q;
   logic [PAYLOAD_W-1:0]      mem_q [FIFO_DEPTH];

   // Assert asynchronously, release on a clock edge so no flop sees a
   // recovery violation.
   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) rst_sync_q <= '0;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   // A grant in flight has already been promised a buffer slot.
   assign push      = |grant_q;
   assign pop       = (count_q != '0) && req_out_ready;
   assign occupancy = count_q + CNT_W'(push);
   assign can_grant = (state_q == ST_BUSY) && (occupancy < AF_THRESH) &&
                      (occupancy < DEPTH_CNT);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      any_valid    = 1'b0;
      eligible     = '0;
      push_payload = '0;
      for (int unsigned i = 0; i < NUM_REQUESTORS; i++) begin
         any_valid    = any_valid | req_in[i].valid;
         eligible[i]  = req_in[i].valid & ~grant_q[i];
         push_payload = push_payload | (req_in[i].payload & {PAYLOAD_W{grant_q[i]}});
      end
   end

   // The requestor popped this cycle still shows its old head, hence the mask.
   always_comb begin
      logic [PTR_W-1:0] cand;
      int unsigned      sum;
      logic             found;
      grant_d  = '0;
      rr_ptr_d = rr_ptr_q;
      cand     = '0;
      sum      = 0;
      found    = 1'b0;
      for (int unsigned k = 0; k < NUM_REQUESTORS; k++) begin
         sum = 32'(rr_ptr_q) + k;
         if (sum >= NUM_REQUESTORS) sum = sum - NUM_REQUESTORS;
         cand = PTR_W'(sum);
         if (can_grant && !found && eligible[cand]) begin
            found          = 1'b1;
            grant_d[cand]  = 1'b1;
            rr_ptr_d       = (32'(cand) == NUM_REQUESTORS - 1) ? '0 : cand + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
   always_ff @(posedge ap_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RESET;
         busy_q   <= 1'b0;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         case (state_q)
            ST_RESET: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            ST_IDLE: begin
               if (any_valid) begin
                  state_q <= ST_BUSY;
                  busy_q  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (occupancy >= AF_THRESH) begin
                  state_q <= ST_PAUSE;
               end else if (!any_valid && !push) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_PAUSE: begin
               if (occupancy < AF_THRESH) state_q <= ST_BUSY;
            end
            default: begin
               state_q <= ST_RESET;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge ap_clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // NOTE: buffer storage is not reset; count_q alone decides which entries are live.
   always_ff @(posedge ap_clk) begin
      if (push) mem_q[wr_ptr_q] <= push_payload;
   end

   assign grant_out        = grant_q;
   assign req_out.valid    = (count_q != '0);
   assign req_out.payload  = mem_q[rd_ptr_q];
   assign fifo_empty       = (count_q == '0);
   assign fifo_almost_full = (occupancy >= AF_THRESH);
   assign arbiter_busy     = busy_q;

endmodule
